// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_if
//  Purpose  : Bundles the three buses of the load/store unit:
//             - request  (execute stage -> LSU, valid/ready)
//             - response (LSU -> execute stage, valid/ready)
//             - data memory port (level-sensitive, mem_en=1 writes)
//  Modports : slave  - the load/store unit itself
//             master - the surrounding system (requester, consumer, memory)
//  Revision : 1.0  initial release
// ============================================================================
interface load_store_unit_if;
    // request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    // response
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    // data memory port
    logic        mem_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_in;
    logic [63:0] mem_out;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, mem_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_addr, mem_in
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, mem_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_addr, mem_in
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Single-outstanding load/store initiator for a 512 x 64-bit data
//             memory. Byte addresses become word indices, sub-dword stores
//             are done as read-modify-write, load data is extracted at the
//             byte offset and sign/zero extended. Misaligned or out-of-range
//             requests are answered with rsp_err and never touch memory.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous, active-high
//             bus   - load_store_unit_if.slave (request, response and
//                     memory port; all outputs registered except req_ready)
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_LIMIT_BITS = 12
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int c_IDX_BITS = ADDR_LIMIT_BITS - 3;

    state_t      r_state;
    state_t      w_state_nxt;

    // latched request
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [2:0]  r_off;
    logic [63:0] r_wdata;
    logic        w_latch;

    // registered outputs and their next values
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic        r_rsp_err,   w_rsp_err_nxt;
    logic [63:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic        r_mem_en,    w_mem_en_nxt;
    logic [63:0] r_mem_addr,  w_mem_addr_nxt;
    logic [63:0] r_mem_in,    w_mem_in_nxt;

    // request decode
    logic        w_range_err;
    logic        w_misalign;
    logic        w_req_err;
    logic [63:0] w_word_idx;

    // datapath on the word returned by memory
    logic [5:0]  w_shift;
    logic [63:0] w_mask;
    logic [63:0] w_shifted;
    logic [63:0] w_load_data;
    logic [63:0] w_merged;

    assign w_range_err = |bus.req_addr[63:ADDR_LIMIT_BITS];
    assign w_req_err   = w_range_err | w_misalign;
    assign w_word_idx  = {{(64 - c_IDX_BITS){1'b0}}, bus.req_addr[ADDR_LIMIT_BITS-1:3]};

    always_comb begin
        w_misalign = 1'b0;
        case (bus.req_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = bus.req_addr[0];
            2'd2:    w_misalign = |bus.req_addr[1:0];
            default: w_misalign = |bus.req_addr[2:0];
        endcase
    end

    // Lane mask is right-aligned; shifting it by the byte offset selects the
    // addressed bytes of the word. Aligned requests never straddle a word.
    assign w_shift   = {r_off, 3'b000};
    assign w_shifted = bus.mem_out >> w_shift;
    assign w_merged  = (bus.mem_out & ~(w_mask << w_shift)) | ((r_wdata & w_mask) << w_shift);

    always_comb begin
        w_mask      = '1;
        w_load_data = w_shifted;
        case (r_size)
            2'd0: begin
                w_mask      = 64'h0000_0000_0000_00FF;
                w_load_data = {{56{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            2'd1: begin
                w_mask      = 64'h0000_0000_0000_FFFF;
                w_load_data = {{48{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            2'd2: begin
                w_mask      = 64'h0000_0000_FFFF_FFFF;
                w_load_data = {{32{r_signed & w_shifted[31]}}, w_shifted[31:0]};
            end
            default: begin
                w_mask      = '1;
                w_load_data = w_shifted;
            end
        endcase
    end

    // Next-state and next-output logic. Every output register holds its value
    // unless a transition below changes it, which keeps mem_addr/mem_in
    // stable around the write strobe and the response stable under stall.
    always_comb begin
        w_state_nxt     = r_state;
        w_latch         = 1'b0;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_mem_en_nxt    = r_mem_en;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_in_nxt    = r_mem_in;

        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_latch        = 1'b1;
                    w_mem_addr_nxt = w_word_idx;
                    if (w_req_err) begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end else if (!bus.req_we || (bus.req_size != 2'd3)) begin
                        w_state_nxt = ST_RD;
                    end else begin
                        // full-word store needs no read, write straight away
                        w_state_nxt  = ST_WR;
                        w_mem_in_nxt = bus.req_wdata;
                        w_mem_en_nxt = 1'b1;
                    end
                end
            end

            ST_RD: begin
                if (r_we) begin
                    w_state_nxt  = ST_WR;
                    w_mem_in_nxt = w_merged;
                    w_mem_en_nxt = 1'b1;
                end else begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = w_load_data;
                end
            end

            ST_WR: begin
                w_state_nxt     = ST_RESP;
                w_mem_en_nxt    = 1'b0;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = 1'b0;
                w_rsp_rdata_nxt = '0;
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_in    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_in    <= w_mem_in_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_off    <= 3'd0;
            r_wdata  <= '0;
        end else if (w_latch) begin
            r_we     <= bus.req_we;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_off    <= bus.req_addr[2:0];
            r_wdata  <= bus.req_wdata;
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_in    = r_mem_in;

endmodule
`default_nettype wire
